// File: rtl/ram_banked_if.sv
// ram_banked_if: request/response bus between a memory client and ram_banked
interface ram_banked_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096
);
  logic req, load, err_inject, req_ready, out_valid, busy, perr;
  logic [$clog2(DEPTH)-1:0] addr;
  logic [WIDTH-1:0] in, out;
  modport master(output req, load, addr, in, err_inject, input req_ready, out, out_valid, busy, perr);
  modport slave(input req, load, addr, in, err_inject, output req_ready, out, out_valid, busy, perr);
endinterface

// File: rtl/ram_banked.sv
// ram_banked: single-port multi-bank word RAM with post-reset zero scrub; define RAM_PARITY_EN for per-word even parity
module ram_banked #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int BANKS = 8
) (
  input logic clk,
  input logic rst,
  ram_banked_if.slave bus
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int BANK_DEPTH = DEPTH / BANKS;
  localparam int LOW_W = $clog2(BANK_DEPTH);
  localparam int CNT_W = LOW_W > 0 ? LOW_W : 1;
  localparam int SEL_W = BANK_W > 0 ? BANK_W : 1;
`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  typedef enum logic {SCRUB, READY} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] scrub_cnt, idx, widx;
  logic [SEL_W-1:0] sel;
  logic scrub, wr, rd_en, out_valid_q;
  logic [MW-1:0] wword, wdata, rword;
  logic [MW-1:0] rd [BANKS];
  logic [WIDTH-1:0] out_q;
  assign sel = SEL_W'(bus.addr >> LOW_W);
  assign idx = LOW_W > 0 ? CNT_W'(bus.addr) : '0;
  assign wr = bus.req && bus.load && !scrub && !rst;
  assign rd_en = bus.req && !bus.load && !scrub && !rst;
  assign widx = scrub ? scrub_cnt : idx;
  assign wdata = scrub ? '0 : wword;
  assign rword = rd[sel];
  assign bus.out = out_q;
  assign bus.out_valid = out_valid_q;
  always_ff @(posedge clk) state <= rst ? SCRUB : state_nxt;
  always_comb state_nxt = (state == SCRUB && scrub_cnt == CNT_W'(BANK_DEPTH - 1)) ? READY : state;
  always_comb begin
    scrub = state == SCRUB;
    bus.busy = scrub;
    bus.req_ready = !scrub;
  end
  always_ff @(posedge clk) scrub_cnt <= rst ? '0 : scrub ? scrub_cnt + 1'b1 : scrub_cnt;
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [MW-1:0] mem [BANK_DEPTH];
    always_ff @(posedge clk) if (scrub || (wr && sel == SEL_W'(b))) mem[widx] <= wdata;
    assign rd[b] = mem[idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_en;
      if (rd_en) out_q <= rword[WIDTH-1:0];
    end
  end
`ifdef RAM_PARITY_EN
  logic perr_q;
  assign wword = {^bus.in ^ bus.err_inject, bus.in};
  assign bus.perr = perr_q;
  always_ff @(posedge clk) perr_q <= !rst && rd_en && (rword[WIDTH] != ^rword[WIDTH-1:0]);
`else
  logic unused_err_inject;
  assign unused_err_inject = bus.err_inject;
  assign wword = bus.in;
  assign bus.perr = 1'b0;
`endif
endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised successor to the fixed-size word RAM cluster: a single-port, multi-bank, word-addressed RAM with generic word width, depth and bank count.
- Address high bits select the bank. Low bits select the word within the bank.
- Adds a registered read path with a valid strobe, a request/ready handshake, and a hardware zero-scrub after reset.
- Used as the data/instruction memory of the CPU and as the backing store for larger memory tiers.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 4096, total words; power of 2.
- BANKS, 8, bank count; power of 2, at most DEPTH.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BANK_W, $clog2(BANKS), bank-select width (addr[ADDR_W-1 -: BANK_W]); derived.
- BANK_DEPTH, DEPTH/BANKS, words per bank; derived.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request, sampled when req_ready=1.
- load  in  1  qualifies req: 1 = write, 0 = read.
- addr  in  ADDR_W  word address.
- in  in  WIDTH  write data.
- err_inject  in  1  parity-fault injection; ignored without RAM_PARITY_EN.
- req_ready  out  1  block accepts a request this cycle.
- out  out  WIDTH  read data, registered.
- out_valid  out  1  one-cycle strobe: out holds fresh read data.
- busy  out  1  scrub in progress.
- perr  out  1  parity error on current out_valid; constant 0 without RAM_PARITY_EN.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out=0, out_valid=0, perr=0, busy=1, req_ready=0, FSM=SCRUB, scrub_cnt=0.
- Memory array contents are not reset directly; they are cleared by the scrub.
- FSM states:
  - SCRUB: each cycle write 0 to word scrub_cnt in all BANKS banks in parallel, then scrub_cnt++.
  - At scrub_cnt=BANK_DEPTH-1, after that write, go to READY. Scrub lasts exactly BANK_DEPTH cycles (512 by default).
  - READY: busy=0, req_ready=1. Stays in READY until rst.
- req_ready = (state==READY), combinational from state.
- req with req_ready=0 is dropped: no write, no out_valid.
- Write (req & load & req_ready): at the edge, bank[addr bank bits][addr low bits] <= in. out and out_valid are unchanged (out_valid=0 next cycle).
- Read (req & !load & req_ready): one-cycle latency. Next cycle out = word at addr and out_valid=1.
  - Without a new read, out_valid returns to 0 and out holds its last value.
- Single port: one access per cycle; back-to-back accesses every cycle allowed.
- Read on the cycle after a write to the same address returns the new data.
- Only the addressed bank's write enable may assert in READY. Other banks are untouched.
- rst mid-scrub: scrub restarts at scrub_cnt=0 with busy=1.
- rst in READY: re-enter SCRUB; any pending out_valid is squashed (0 next cycle) and memory is re-zeroed.
- rst has priority over req in the same cycle.
- Address range: addr always maps in range because DEPTH is a power of 2. No wrap or overflow logic is needed.
- scrub_cnt is BANK_W-independent, $clog2(BANK_DEPTH) bits wide, minimum 1 bit.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit (^in) on write.
  - If err_inject=1 with the write, the stored parity bit is inverted.
  - Scrub writes data 0 with parity 0.
  - On read, perr = (stored parity != ^stored data), asserted in the same cycle as out_valid; perr=0 whenever out_valid=0.
- Undefined: no parity storage; err_inject ignored; perr tied 0.

Test Plan:
- Reset scrub: assert rst 1 cycle, then idle. busy=1 and req_ready=0 for exactly 512 cycles, then busy=0 and req_ready=1. A read of addr 0x0FFF returns 0x0000 with out_valid 1 cycle after req.
- Write then read: write 0xBEEF to 0x0A05, next cycle read 0x0A05. out=0xBEEF with out_valid=1 one cycle after the read. The write cycle itself produces out_valid=0.
- Bank isolation: write 0x1111 to 0x0000, 0x2222 to 0x0200, 0x8888 to 0x0E00, then read all three. Results 0x1111, 0x2222, 0x8888 in order; 0x0001 and 0x0201 still read 0.
- Blocked request: req=1, load=1, addr 0x0010, in 0x5555 issued during scrub cycle 100. Write is ignored; after scrub, 0x0010 reads 0.
- Reset mid-operation: fill 0x0123=0xCAFE; assert rst in READY concurrently with a read of 0x0123. No out_valid follows, busy=1 for 512 cycles, and 0x0123 then reads 0.
- Parity (RAM_PARITY_EN): write 0x0007 with err_inject=1 to 0x0004, then read it. out=0x0007, out_valid=1, perr=1. The same with err_inject=0 gives perr=0; without the macro perr=0 always.
